idp_decoder_29: RTL

Multi-cycle decoder for the 29-bit FNS crosstalk-avoidance codeword. It sits directly downstream of the 29-bit IDP encoder, at the receive end of the coded bus. It accepts one registered codeword through a valid/ready handshake and rebuilds the `IBLEN29`-bit data word by iterative weighted accumulation. It flags any codeword whose 4 MSBs are not a legal prefix.

---
 rtl/idp_decoder_29.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/idp_decoder_29.sv
// ---------------------------------------------------------------------------
// idp_decoder_29
//
// Purpose:
//   Receive-side decoder for the 29-bit FNS crosstalk-avoidance codeword.
//   A codeword is captured through a valid/ready handshake and the data word
//   is rebuilt by iterative weighted accumulation, STEP low-field bits per
//   cycle, starting from the offset selected by the 4-bit MSB prefix.
//   Illegal prefixes contribute no offset and raise msb_err; the low field
//   is still decoded.
//
// Parameters:
//   STEP     low-field bits consumed per ACCUM cycle (1, 5 or 25)
//   IBLEN29  width of the decoded data word / accumulator
//
// Ports:
//   clock      in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   codein is valid
//   in_ready   out  block can accept a codeword (state == IDLE)
//   codein     in   29-bit codeword, [28:25] prefix, [24:0] low FNS field
//   out_valid  out  dataout / msb_err are valid
//   out_ready  in   consumer accepts the result
//   dataout    out  decoded data word
//   msb_err    out  prefix of the decoded word was illegal
// ---------------------------------------------------------------------------
module idp_decoder_29 #(
    parameter int STEP    = 5,
    parameter int IBLEN29 = 22
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [28:0]        codein,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IBLEN29-1:0] dataout,
    output logic               msb_err
);

    localparam int K     = 25 / STEP;
    localparam int CNT_W = 5;

    // FNS(n): Fibonacci-style weights with FNS(1)=1, FNS(2)=2, FNS(n)=FNS(n-1)+FNS(n-2).
    function automatic logic [IBLEN29-1:0] fns(input int n);
        logic [IBLEN29-1:0] a;
        logic [IBLEN29-1:0] b;
        logic [IBLEN29-1:0] t;
        a = IBLEN29'(1);
        b = IBLEN29'(2);
        if (n <= 1) begin
            return a;
        end
        for (int i = 2; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    // Bit 0 weighs 1; bit k (k >= 1) weighs FNS(k+1).
    function automatic logic [IBLEN29-1:0] bitWeight(input int k);
        if (k == 0) begin
            return IBLEN29'(1);
        end
        return fns(k + 1);
    endfunction

    localparam logic [IBLEN29-1:0] FNS26 = fns(26);
    localparam logic [IBLEN29-1:0] FNS28 = fns(28);
    localparam logic [IBLEN29-1:0] FNS29 = fns(29);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [24:0]        r_shift;
    logic [IBLEN29-1:0] r_acc;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_inReady;
    logic               r_outValid;

    logic [IBLEN29-1:0] w_weight [0:24];
    logic [IBLEN29-1:0] w_offset;
    logic               w_err;
    logic [IBLEN29-1:0] w_groupSum;

    for (genvar k = 0; k < 25; k++) begin : g_weight
        assign w_weight[k] = bitWeight(k);
    end

    // Prefix offset lookup; anything outside the ten legal prefixes is an error
    // and contributes nothing to the sum.
    always_comb begin
        w_offset = '0;
        w_err    = 1'b0;
        case (codein[28:25])
            4'b0000: w_offset = '0;
            4'b0001: w_offset = FNS26;
            4'b1000: w_offset = FNS28;
            4'b1001: w_offset = FNS26 + FNS28;
            4'b0011: w_offset = FNS26 + FNS29;
            4'b1100: w_offset = FNS28 + FNS29;
            4'b0110: w_offset = FNS29 + FNS29;
            4'b0111: w_offset = FNS29 + FNS29 + FNS26;
            4'b1110: w_offset = FNS29 + FNS29 + FNS28;
            4'b1111: w_offset = FNS29 + FNS29 + FNS28 + FNS26;
            default: begin
                w_offset = '0;
                w_err    = 1'b1;
            end
        endcase
    end

    // The shift register always presents the current group in its top STEP
    // bits; the counter tells which absolute bit positions (and so which
    // weights) those bits carry.
    always_comb begin : p_groupSum
        int base;
        int idx;
        w_groupSum = '0;
        base       = 24 - (K - 1 - int'(r_cnt)) * STEP;
        for (int j = 0; j < STEP; j++) begin
            idx = base - j;
            if (r_shift[24-j]) begin
                w_groupSum = w_groupSum + w_weight[idx[4:0]];
            end
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_acc      <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift   <= codein[24:0];
                        r_acc     <= w_offset;
                        r_err     <= w_err;
                        r_cnt     <= CNT_W'(K - 1);
                        r_inReady <= 1'b0;
                        r_state   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_acc   <= r_acc + w_groupSum;
                    r_shift <= r_shift << STEP;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_outValid <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign dataout   = r_acc;
    assign msb_err   = r_err;

endmodule
